// File: rtl/feistel_deciph_seq.sv
// Iterative 16-bit Feistel decryptor that runs one round per clock, driven by an IDLE/RUN/DONE FSM.
// Defining FEISTEL_DEC_BLKCNT_EN adds the blk_cnt output handshake counter.
module feistel_deciph_seq #(
    parameter int ROUNDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  pt,
`ifdef FEISTEL_DEC_BLKCNT_EN
    output logic [15:0]  blk_cnt,
`endif
    output logic         busy
);

    generate
        if (ROUNDS < 1 || ROUNDS > 8) begin : g_bad_rounds
            $error("feistel_deciph_seq: ROUNDS must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] RND_LAST = 3'(ROUNDS - 1);

    state_t       state;
    logic [7:0]   l_q;
    logic [7:0]   r_q;
    logic [127:0] key_q;
    logic [2:0]   rnd;

    logic [6:0]   w_base;
    logic [15:0]  w_rnd;
    logic [7:0]   k_rnd;
    logic [7:0]   f_mix;
    logic [7:0]   f_out;

    // Round word W_i sits at bit offset (7-i)*16, so W_0 is the top 16 key bits.
    always_comb begin
        w_base = {3'd7 - rnd, 4'b0000};
        w_rnd  = key_q[w_base +: 16];
        k_rnd  = w_rnd[15:8] ^ w_rnd[7:0];
        f_mix  = l_q ^ k_rnd;
        f_out  = {f_mix[4:0], f_mix[7:5]} + k_rnd;
    end

    assign pt = {l_q, r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            l_q       <= 8'h00;
            r_q       <= 8'h00;
            key_q     <= '0;
            rnd       <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l_q      <= ct[15:8];
                        r_q      <= ct[7:0];
                        key_q    <= key;
                        rnd      <= RND_LAST;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_q <= l_q;
                    l_q <= r_q ^ f_out;
                    if (rnd == 3'd0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FEISTEL_DEC_BLKCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= 16'h0000;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 16'h0001;
        end
    end
`endif

endmodule
